switch_debounce_toggle: RTL and testbench
=========================================

// Module: switch_debounce_toggle
// PURPOSE
//   Input conditioner for the Go Board push-button switches. Each raw asynchronous
//   switch is synchronised and debounced, then edge-detected into one-cycle press
//   and release pulses. A toggle register per switch drives an LED.
//   Sits between the board pins and any logic that consumes switch state.
// PARAMETERS
//   N_SW            4       number of switch channels
//   DEBOUNCE_LIMIT  250000  consecutive stable cycles to accept a change (10 ms @ 25 MHz); must be >= 2
// PORTS
//   i_Clk            in   1      system clock, rising edge
//   i_Rst_L          in   1      asynchronous active-low reset
//   i_Switch         in   N_SW   raw switch inputs, asynchronous, 1 = pressed
//   o_Switch_Level   out  N_SW   debounced switch level
//   o_Press_Pulse    out  N_SW   1-cycle pulse on debounced 0->1
//   o_Release_Pulse  out  N_SW   1-cycle pulse on debounced 1->0
//   o_LED_Toggle     out  N_SW   inverts on each press pulse
// BEHAVIOUR
//   - One clock (i_Clk). Reset i_Rst_L is asynchronous and active-low.
//     Assertion immediately clears all flops. Release is synchronous to i_Clk at the board level.
//   - Reset values: sync FFs 0, counters 0, o_Switch_Level 0, both pulse outputs 0, o_LED_Toggle 0.
//   - Per channel: 2-FF synchroniser r1 -> r2. No logic is placed between r1 and r2.
//   - Debounce counter:
//     * width $clog2(DEBOUNCE_LIMIT).
//     * Each edge with r2 != level and count < LIMIT-1: count++.
//     * Each edge with r2 != level and count == LIMIT-1: level <= r2, count <= 0.
//     * Each edge with r2 == level: count <= 0, so any bounce restarts the window.
//     * The counter never wraps.
//   - Per-channel FSM, implicit in the counter:
//     * STABLE (count = 0, r2 == level).
//     * COUNTING (r2 != level).
//     * COUNTING -> STABLE on acceptance, or on a glitch return.
//   - Latency: a clean input change is reflected on o_Switch_Level after LIMIT+2 rising edges.
//     Edge 1 is the first edge at which r1 samples the new value.
//   - Filtering: an input excursion shorter than LIMIT cycles as seen at r2 produces no
//     output change. Exactly LIMIT cycles is accepted.
//   - Pulses:
//     * Registered and asserted in the same cycle o_Switch_Level changes; high for exactly 1 cycle.
//     * Press and release are never high together on one channel.
//   - o_LED_Toggle[n] flips on the edge after o_Press_Pulse[n] = 1, i.e. 1 cycle after the pulse.
//   - Channels are fully independent. Simultaneous events on several channels are each
//     handled in the same cycle, with no priority.
//   - Reset mid-count discards the partial count.
//     * A switch held pressed through reset release yields a press pulse LIMIT+2 edges after release.
//     * That press toggles the LED.
//   - All outputs are registered. There is no combinational path from i_Switch to any output.
// TESTING (bench uses DEBOUNCE_LIMIT=8, N_SW=4)
//   1. Reset, all switches 0, 20 cycles -> every output 0. Assert i_Rst_L=0 mid-run -> outputs 0
//      immediately, without waiting for a clock edge.
//   2. i_Switch[0] 0->1, held -> o_Switch_Level[0] rises 10 edges later. o_Press_Pulse[0] high 1 cycle
//      in that same cycle. o_LED_Toggle[0] goes 1 on the next edge.
//   3. i_Switch[1] high 7 cycles then low -> no level, pulse or LED change.
//      Repeat with 8 cycles -> press, then release 10 edges after the drop.
//   4. Bounce on sw2: 1,0,1,0 every 3 cycles, then steady 1 -> exactly one press pulse,
//      10 edges after the final 0->1.
//   5. Switches 0 and 3 pressed in the same cycle -> both press pulses in the same cycle.
//      Press/release sw3 twice -> o_LED_Toggle[3] sequence 1,0.
//   6. Hold sw1 high, pulse reset for 3 cycles at count 5 -> outputs clear.
//      Press pulse occurs 10 edges after reset release.

Source files
------------

// File: rtl/switch_debounce_toggle_if.sv
// Switch conditioner bundle: raw switch pins in, debounced level,
// edge pulses and LED toggles out.
interface switch_debounce_toggle_if #(
    parameter int N_SW = 4
);
    logic [N_SW-1:0] i_Switch;
    logic [N_SW-1:0] o_Switch_Level;
    logic [N_SW-1:0] o_Press_Pulse;
    logic [N_SW-1:0] o_Release_Pulse;
    logic [N_SW-1:0] o_LED_Toggle;

    modport master (
        output i_Switch,
        input  o_Switch_Level,
        input  o_Press_Pulse,
        input  o_Release_Pulse,
        input  o_LED_Toggle
    );

    modport slave (
        input  i_Switch,
        output o_Switch_Level,
        output o_Press_Pulse,
        output o_Release_Pulse,
        output o_LED_Toggle
    );
endinterface

// File: rtl/switch_debounce_toggle.sv
// Push-button conditioner: 2-FF sync, stable-window debounce,
// press/release pulses and a per-switch LED toggle.
module switch_debounce_toggle #(
    parameter int N_SW           = 4,
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input logic                     i_Clk,
    input logic                     i_Rst_L,
    switch_debounce_toggle_if.slave sw_if
);
    localparam int CW = (DEBOUNCE_LIMIT > 2) ? $clog2(DEBOUNCE_LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_LIMIT - 1);

    logic [N_SW-1:0] r_Sync1;
    logic [N_SW-1:0] r_Sync2;
    logic [N_SW-1:0] r_Level;
    logic [N_SW-1:0] r_Press;
    logic [N_SW-1:0] r_Release;
    logic [N_SW-1:0] r_Led;
    logic [CW-1:0]   r_Count [N_SW];

    // A change is accepted only after LIMIT consecutive samples differ
    // from the current level; any sample matching the level restarts it.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_Sync1   <= '0;
            r_Sync2   <= '0;
            r_Level   <= '0;
            r_Press   <= '0;
            r_Release <= '0;
            r_Led     <= '0;
            for (int n = 0; n < N_SW; n++) begin
                r_Count[n] <= '0;
            end
        end else begin
            r_Sync1 <= sw_if.i_Switch;
            r_Sync2 <= r_Sync1;
            r_Led   <= r_Led ^ r_Press;
            for (int n = 0; n < N_SW; n++) begin
                r_Press[n]   <= 1'b0;
                r_Release[n] <= 1'b0;
                if (r_Sync2[n] == r_Level[n]) begin
                    r_Count[n] <= '0;
                end else if (r_Count[n] == LAST) begin
                    r_Count[n]   <= '0;
                    r_Level[n]   <= r_Sync2[n];
                    r_Press[n]   <= r_Sync2[n];
                    r_Release[n] <= ~r_Sync2[n];
                end else begin
                    r_Count[n] <= r_Count[n] + CW'(1);
                end
            end
        end
    end

    assign sw_if.o_Switch_Level  = r_Level;
    assign sw_if.o_Press_Pulse   = r_Press;
    assign sw_if.o_Release_Pulse = r_Release;
    assign sw_if.o_LED_Toggle    = r_Led;
endmodule

// File: tb/tb_switch_debounce_toggle.sv
// Bench for switch_debounce_toggle: expected output snapshots are queued
// with their due cycle when stimulus is driven, and checked on negedge.
module tb_switch_debounce_toggle;
    localparam int N   = 4;
    localparam int LIM = 8;
    localparam int LAT = LIM + 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    switch_debounce_toggle_if #(.N_SW(N)) sw_if ();

    switch_debounce_toggle #(
        .N_SW(N),
        .DEBOUNCE_LIMIT(LIM)
    ) dut (
        .i_Clk  (clk),
        .i_Rst_L(rst_n),
        .sw_if  (sw_if)
    );

    typedef struct {
        int         cyc;
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [3:0] rel;
        logic [3:0] led;
        string      tag;
    } exp_t;

    typedef struct {
        int ch;
        int len;
        bit accept;
    } flt_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    logic [3:0] lvl_e = '0;
    logic [3:0] led_e = '0;
    logic [3:0] sw    = '0;

    always @(posedge clk) cyc++;

    task automatic check(string tag, logic [3:0] l, logic [3:0] p,
                         logic [3:0] r, logic [3:0] d);
        n_cmp++;
        if (sw_if.o_Switch_Level !== l || sw_if.o_Press_Pulse !== p ||
            sw_if.o_Release_Pulse !== r || sw_if.o_LED_Toggle !== d) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got lvl=%b prs=%b rel=%b led=%b, want lvl=%b prs=%b rel=%b led=%b",
                     tag, cyc, sw_if.o_Switch_Level, sw_if.o_Press_Pulse,
                     sw_if.o_Release_Pulse, sw_if.o_LED_Toggle, l, p, r, d);
        end
    endtask

    always @(negedge clk) begin
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].cyc == cyc) begin
                check(sbq[i].tag, sbq[i].lvl, sbq[i].prs, sbq[i].rel, sbq[i].led);
                sbq.delete(i);
            end else if (sbq[i].cyc < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s: expectation for cyc %0d expired at %0d",
                         sbq[i].tag, sbq[i].cyc, cyc);
                sbq.delete(i);
            end
        end
    end

    function automatic void push(int c, logic [3:0] l, logic [3:0] p,
                                 logic [3:0] r, logic [3:0] d, string tag);
        exp_t e;
        e.cyc = c;
        e.lvl = l;
        e.prs = p;
        e.rel = r;
        e.led = d;
        e.tag = tag;
        sbq.push_back(e);
    endfunction

    function automatic void hold(int c0, int c1, string tag);
        for (int c = c0; c <= c1; c++) push(c, lvl_e, '0, '0, led_e, tag);
    endfunction

    // Debounced edge of channels m at cycle c, with the cycles around it.
    function automatic void edge_at(int c, logic [3:0] m, bit press, string tag);
        logic [3:0] nl;
        logic [3:0] nd;
        nl = press ? (lvl_e | m) : (lvl_e & ~m);
        nd = press ? (led_e ^ m) : led_e;
        push(c - 1, lvl_e, '0, '0, led_e, {tag, "_pre"});
        push(c, nl, press ? m : 4'h0, press ? 4'h0 : m, led_e, {tag, "_edge"});
        push(c + 1, nl, '0, '0, nd, {tag, "_post"});
        lvl_e = nl;
        led_e = nd;
    endfunction

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(logic [3:0] v);
        sw = v;
        sw_if.i_Switch = v;
    endtask

    // Hold-length table: 7 cycles is a glitch, LIM cycles is a real press.
    flt_t ft[5];

    initial begin
        int c;
        int cf;
        ft[0] = '{1, LIM - 1, 1'b0};
        ft[1] = '{1, LIM,     1'b1};
        ft[2] = '{2, 1,       1'b0};
        ft[3] = '{3, 3,       1'b0};
        ft[4] = '{0, LIM + 3, 1'b1};

        drive(4'h0);
        step(3);
        check("in_reset", '0, '0, '0, '0);
        rst_n = 1'b1;
        c = cyc;
        hold(c + 1, c + 20, "reset_idle");
        step(21);

        // Single clean press on sw0.
        c = cyc;
        drive(4'b0001);
        hold(c + 1, c + LAT - 2, "sw0_wait");
        edge_at(c + LAT, 4'b0001, 1'b1, "sw0_press");
        step(LAT + 3);

        // Asynchronous reset between clock edges.
        #2;
        rst_n = 1'b0;
        drive(4'h0);
        #1;
        check("async_reset", '0, '0, '0, '0);
        lvl_e = '0;
        led_e = '0;
        step(2);
        rst_n = 1'b1;
        c = cyc;
        hold(c + 1, c + 5, "post_reset");
        step(6);

        // Pulse-length table.
        for (int k = 0; k < 5; k++) begin
            logic [3:0] m;
            string tg;
            m = 4'(1 << ft[k].ch);
            tg = $sformatf("flt%0d", k);
            c = cyc;
            drive(sw | m);
            if (ft[k].accept) begin
                hold(c + 1, c + LAT - 2, tg);
                edge_at(c + LAT, m, 1'b1, {tg, "_p"});
                hold(c + LAT + 2, c + ft[k].len + LAT - 2, tg);
                edge_at(c + ft[k].len + LAT, m, 1'b0, {tg, "_r"});
            end else begin
                hold(c + 1, c + ft[k].len + LAT + 2, tg);
            end
            step(ft[k].len);
            drive(sw & ~m);
            step(LAT + 4);
        end

        // Bounce on sw2: 1,0,1,0 every 3 cycles, then steady 1.
        c  = cyc;
        cf = c + 12;
        hold(c + 1, cf + LAT - 2, "bounce");
        edge_at(cf + LAT, 4'b0100, 1'b1, "bounce_press");
        drive(sw | 4'b0100);
        step(3);
        drive(sw & ~4'b0100);
        step(3);
        drive(sw | 4'b0100);
        step(3);
        drive(sw & ~4'b0100);
        step(3);
        drive(sw | 4'b0100);
        step(LAT + 3);
        c = cyc;
        drive(sw & ~4'b0100);
        hold(c + 1, c + LAT - 2, "sw2_drop");
        edge_at(c + LAT, 4'b0100, 1'b0, "sw2_release");
        step(LAT + 3);

        // sw0 and sw3 together, then sw3 a second time.
        c = cyc;
        drive(4'b1001);
        hold(c + 1, c + LAT - 2, "dual");
        edge_at(c + LAT, 4'b1001, 1'b1, "dual_press");
        step(LAT + 3);
        c = cyc;
        drive(4'b0000);
        edge_at(c + LAT, 4'b1001, 1'b0, "dual_release");
        step(LAT + 3);
        c = cyc;
        drive(4'b1000);
        edge_at(c + LAT, 4'b1000, 1'b1, "sw3_press2");
        step(LAT + 3);
        c = cyc;
        drive(4'b0000);
        edge_at(c + LAT, 4'b1000, 1'b0, "sw3_release2");
        step(LAT + 3);

        // sw1 held through a reset that lands at count 5.
        c = cyc;
        drive(4'b0010);
        hold(c + 1, c + 6, "mid_count");
        step(7);
        #1;
        rst_n = 1'b0;
        #1;
        check("midcount_reset", '0, '0, '0, '0);
        lvl_e = '0;
        led_e = '0;
        step(3);
        rst_n = 1'b1;
        c = cyc;
        hold(c + 1, c + LAT - 2, "rst_hold");
        edge_at(c + LAT, 4'b0010, 1'b1, "rst_press");
        step(LAT + 3);
        c = cyc;
        drive(4'b0000);
        edge_at(c + LAT, 4'b0010, 1'b0, "rst_release");
        step(LAT + 3);

        for (int w = 0; w < 50 && sbq.size() != 0; w++) step(1);
        if (sbq.size() != 0) begin
            n_cmp += sbq.size();
            n_bad += sbq.size();
            $display("FAIL drain: %0d expectations never checked, want 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end
endmodule
